motor_ramp_ctrl: RTL and testbench

Speed-ramp and direction sequencer for the motor PWM path. It takes speed commands as direction plus magnitude and steps the `pwm_thres` of the PWM generator toward the target by a bounded amount once per PWM period. Updates are aligned to the generator's period-start pulse. A direction reversal is sequenced as ramp-down, then a dead interval at zero, then the direction flip, then ramp-up. An emergency stop overrides everything.

---
 rtl/motor_ctrl_pkg.sv | 24 ++
 rtl/thres_stepper.sv | 38 +++
 rtl/motor_ramp_ctrl.sv | 129 ++++++++++++
 tb/tb_motor_ramp_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_ctrl_pkg.sv
// Shared types and widths for the motor speed-ramp sequencer.
// The state enum is exported so benches and checkers can decode the debug state output.
package motor_ctrl_pkg;

    localparam int THRES_W    = 16;
    localparam int DEAD_CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RAMP  = 3'd1,
        ST_BRAKE = 3'd2,
        ST_DEAD  = 3'd3,
        ST_ESTOP = 3'd4
    } state_t;

    // Limit a commanded magnitude to the PWM period.
    function automatic logic [THRES_W-1:0] clamp_mag(
        input logic [THRES_W-1:0] mag,
        input logic [THRES_W-1:0] max_mag
    );
        clamp_mag = (mag > max_mag) ? max_mag : mag;
    endfunction

endpackage

// File: rtl/thres_stepper.sv
// Combinational one-period threshold step: moves cur toward tgt by at most step,
// or toward zero (saturating) when brake is set.
module thres_stepper
    import motor_ctrl_pkg::*;
(
    input  logic [THRES_W-1:0] cur,
    input  logic [THRES_W-1:0] tgt,
    input  logic [THRES_W-1:0] step,
    input  logic               brake,
    output logic [THRES_W-1:0] nxt
);

    logic [THRES_W:0] cur_x;
    logic [THRES_W:0] tgt_x;
    logic [THRES_W:0] step_x;
    logic [THRES_W:0] diff_x;
    logic [THRES_W:0] sum_x;

    always_comb begin
        cur_x  = {1'b0, cur};
        tgt_x  = {1'b0, tgt};
        step_x = {1'b0, step};
        diff_x = '0;
        sum_x  = cur_x + step_x;
        nxt    = cur;
        if (brake) begin
            nxt = (cur_x <= step_x) ? '0 : (cur - step);
        end else if (tgt_x >= cur_x) begin
            diff_x = tgt_x - cur_x;
            // sum_x stays below tgt here, so dropping the carry bit loses nothing
            nxt    = (diff_x <= step_x) ? tgt : sum_x[THRES_W-1:0];
        end else begin
            diff_x = cur_x - tgt_x;
            nxt    = (diff_x <= step_x) ? tgt : (cur - step);
        end
    end

endmodule

// File: rtl/motor_ramp_ctrl.sv
// Speed-ramp and direction sequencer: steps pwm_thres once per PWM period toward the
// commanded magnitude, sequencing reversals as brake -> dead time -> flip -> ramp.
module motor_ramp_ctrl
    import motor_ctrl_pkg::*;
#(
    parameter logic [15:0] MAX_THRES    = 16'd20000,
    parameter logic [15:0] RAMP_STEP    = 16'd100,
    parameter logic [3:0]  DEAD_PERIODS = 4'd5
) (
    input  logic               in_clk,
    input  logic               in_rst_n,
    // cmd_valid/cmd_ready: a command transfers in any cycle where both are high;
    // ready is simply ~estop and does not depend on valid.
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_dir,
    input  logic [THRES_W-1:0] cmd_mag,
    input  logic               period_start,
    input  logic               estop,
    output logic [THRES_W-1:0] pwm_thres,
    output logic               motor_dir,
    output logic               at_target,
    output logic               busy,
    output logic [2:0]         dbg_state
);

    state_t                state_q, state_d;
    logic                  tgt_dir_q, tgt_dir_d;
    logic [THRES_W-1:0]    tgt_mag_q, tgt_mag_d;
    logic [THRES_W-1:0]    pwm_thres_q, pwm_thres_d;
    logic                  motor_dir_q, motor_dir_d;
    logic [DEAD_CNT_W-1:0] dead_cnt_q, dead_cnt_d;

    logic                  cmd_fire;
    logic                  dir_mismatch;
    logic [THRES_W-1:0]    step_nxt;

    assign cmd_ready = ~estop;
    assign cmd_fire  = cmd_valid & cmd_ready;

    // A zero target carries no direction, so it can never request a flip.
    assign dir_mismatch = (tgt_mag_q != '0) && (tgt_dir_q != motor_dir_q);

    thres_stepper u_stepper (
        .cur   (pwm_thres_q),
        .tgt   (tgt_mag_q),
        .step  (RAMP_STEP),
        .brake (dir_mismatch),
        .nxt   (step_nxt)
    );

    always_comb begin
        state_d     = state_q;
        tgt_dir_d   = tgt_dir_q;
        tgt_mag_d   = tgt_mag_q;
        pwm_thres_d = pwm_thres_q;
        motor_dir_d = motor_dir_q;
        dead_cnt_d  = dead_cnt_q;

        if (cmd_fire) begin
            tgt_dir_d = cmd_dir;
            tgt_mag_d = clamp_mag(cmd_mag, MAX_THRES);
        end

        if (estop) begin
            state_d     = ST_ESTOP;
            pwm_thres_d = '0;
            tgt_mag_d   = '0;
            dead_cnt_d  = '0;
        end else if (state_q == ST_ESTOP) begin
            state_d = ST_IDLE;
        end else if (period_start) begin
            unique case (state_q)
                ST_IDLE, ST_RAMP, ST_BRAKE: begin
                    pwm_thres_d = step_nxt;
                    if (dir_mismatch) begin
                        dead_cnt_d = '0;
                        state_d    = (step_nxt == '0) ? ST_DEAD : ST_BRAKE;
                    end else begin
                        state_d = (step_nxt == tgt_mag_q) ? ST_IDLE : ST_RAMP;
                    end
                end
                ST_DEAD: begin
                    if (!dir_mismatch) begin
                        // Reversal withdrawn: resume in the current direction at once.
                        pwm_thres_d = step_nxt;
                        dead_cnt_d  = '0;
                        state_d     = (step_nxt == tgt_mag_q) ? ST_IDLE : ST_RAMP;
                    end else begin
                        dead_cnt_d = dead_cnt_q + 1'b1;
                        if (dead_cnt_d == DEAD_PERIODS) begin
                            motor_dir_d = ~motor_dir_q;
                            dead_cnt_d  = '0;
                            state_d     = ST_RAMP;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q     <= ST_IDLE;
            tgt_dir_q   <= 1'b0;
            tgt_mag_q   <= '0;
            pwm_thres_q <= '0;
            motor_dir_q <= 1'b0;
            dead_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            tgt_dir_q   <= tgt_dir_d;
            tgt_mag_q   <= tgt_mag_d;
            pwm_thres_q <= pwm_thres_d;
            motor_dir_q <= motor_dir_d;
            dead_cnt_q  <= dead_cnt_d;
        end
    end

    assign pwm_thres = pwm_thres_q;
    assign motor_dir = motor_dir_q;
    assign at_target = (state_q == ST_IDLE);
    assign busy      = ~at_target;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Directed bench for motor_ramp_ctrl: ramp, reversal with dead time, clamp, dead-time
// abort, emergency stop, asynchronous reset and command/period_start collisions.
module tb_motor_ramp_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_dir;
    logic [15:0] cmd_mag;
    logic        period_start;
    logic        estop;
    logic [15:0] pwm_thres;
    logic        motor_dir;
    logic        at_target;
    logic        busy;
    logic [2:0]  dbg_state;

    int n_cmp;
    int n_err;

    motor_ramp_ctrl dut (
        .in_clk       (clk),
        .in_rst_n     (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_dir      (cmd_dir),
        .cmd_mag      (cmd_mag),
        .period_start (period_start),
        .estop        (estop),
        .pwm_thres    (pwm_thres),
        .motor_dir    (motor_dir),
        .at_target    (at_target),
        .busy         (busy),
        .dbg_state    (dbg_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks: inputs change 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic dir, input logic [15:0] mag);
        cmd_valid = 1'b1;
        cmd_dir   = dir;
        cmd_mag   = mag;
        tick();
        cmd_valid = 1'b0;
    endtask

    // One period_start pulse; outputs are sampled in the cycle right after it.
    task automatic pulse();
        period_start = 1'b1;
        tick();
        period_start = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_cycles(2);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cmd_valid = 1'b1;
        cmd_dir = 1'b1;
        cmd_mag = 16'd500;
        idle_cycles(3);
        n_cmp++; if (pwm_thres !== 16'd0) begin n_err++; $display("FAIL reset_pwm: got %0d want 0", pwm_thres); end
        n_cmp++; if (motor_dir !== 1'b0) begin n_err++; $display("FAIL reset_dir: got %0b want 0", motor_dir); end
        n_cmp++; if (at_target !== 1'b1) begin n_err++; $display("FAIL reset_at_target: got %0b want 1", at_target); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b want 0", busy); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %0b want 1", cmd_ready); end
        estop = 1'b1;
        #1;
        n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready_estop: got %0b want 0", cmd_ready); end
        estop = 1'b0;
        tick();
        // the command held during reset must not have been captured
        rst_n = 1'b1;
        cmd_valid = 1'b0;
        tick();
        pulse();
        n_cmp++; if (pwm_thres !== 16'd0) begin n_err++; $display("FAIL reset_cmd_ignored: pwm got %0d want 0", pwm_thres); end
        n_cmp++; if (motor_dir !== 1'b0) begin n_err++; $display("FAIL reset_cmd_ignored_dir: got %0b want 0", motor_dir); end
        n_cmp++; if (at_target !== 1'b1) begin n_err++; $display("FAIL reset_cmd_ignored_idle: at_target got %0b want 1", at_target); end
    endtask

    task automatic test_ramp_up();
        logic [15:0] exp_seq [4];
        exp_seq = '{16'd100, 16'd200, 16'd300, 16'd350};
        send_cmd(1'b0, 16'd350);
        idle_cycles(3);
        n_cmp++; if (pwm_thres !== 16'd0) begin n_err++; $display("FAIL ramp_no_pulse: pwm got %0d want 0", pwm_thres); end
        for (int i = 0; i < 4; i++) begin
            pulse();
            n_cmp++; if (pwm_thres !== exp_seq[i]) begin n_err++; $display("FAIL ramp_step%0d: pwm got %0d want %0d", i, pwm_thres, exp_seq[i]); end
            n_cmp++; if (at_target !== (i == 3)) begin n_err++; $display("FAIL ramp_at_target%0d: got %0b want %0b", i, at_target, (i == 3)); end
            idle_cycles(2);
            n_cmp++; if (pwm_thres !== exp_seq[i]) begin n_err++; $display("FAIL ramp_hold%0d: pwm got %0d want %0d", i, pwm_thres, exp_seq[i]); end
        end
    endtask

    task automatic test_reversal();
        logic [15:0] exp_pwm [11];
        logic        exp_dir [11];
        exp_pwm = '{16'd250, 16'd150, 16'd50, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd100, 16'd200};
        exp_dir = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        send_cmd(1'b1, 16'd200);
        for (int i = 0; i < 11; i++) begin
            pulse();
            n_cmp++; if (pwm_thres !== exp_pwm[i]) begin n_err++; $display("FAIL rev_pwm%0d: got %0d want %0d", i, pwm_thres, exp_pwm[i]); end
            n_cmp++; if (motor_dir !== exp_dir[i]) begin n_err++; $display("FAIL rev_dir%0d: got %0b want %0b", i, motor_dir, exp_dir[i]); end
            idle_cycles(2);
        end
        n_cmp++; if (at_target !== 1'b1) begin n_err++; $display("FAIL rev_at_target: got %0b want 1", at_target); end
    endtask

    task automatic test_dead_abort();
        logic [15:0] exp_pwm [4];
        exp_pwm = '{16'd100, 16'd0, 16'd0, 16'd0};
        // from 200 forward(dir 1): reverse request, brake to 0, two dead periods
        send_cmd(1'b0, 16'd100);
        for (int i = 0; i < 4; i++) begin
            pulse();
            n_cmp++; if (pwm_thres !== exp_pwm[i]) begin n_err++; $display("FAIL abort_pwm%0d: got %0d want %0d", i, pwm_thres, exp_pwm[i]); end
            n_cmp++; if (motor_dir !== 1'b1) begin n_err++; $display("FAIL abort_dir%0d: got %0b want 1", i, motor_dir); end
            idle_cycles(2);
        end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL abort_busy_dead: got %0b want 1", busy); end
        send_cmd(1'b1, 16'd100);
        pulse();
        n_cmp++; if (pwm_thres !== 16'd100) begin n_err++; $display("FAIL abort_resume_pwm: got %0d want 100", pwm_thres); end
        n_cmp++; if (motor_dir !== 1'b1) begin n_err++; $display("FAIL abort_resume_dir: got %0b want 1", motor_dir); end
        n_cmp++; if (at_target !== 1'b1) begin n_err++; $display("FAIL abort_resume_idle: got %0b want 1", at_target); end
        idle_cycles(2);
    endtask

    task automatic test_clamp();
        logic [15:0] exp_pwm;
        int          n_pulses;
        exp_pwm  = 16'd100;
        n_pulses = 0;
        send_cmd(1'b1, 16'd30000);
        while (at_target !== 1'b1 || n_pulses == 0) begin
            if (n_pulses >= 300) begin
                n_cmp++; n_err++;
                $display("FAIL clamp_timeout: pulses got %0d want 199", n_pulses);
                break;
            end
            pulse();
            n_pulses++;
            exp_pwm = (exp_pwm + 16'd100 > 16'd20000) ? 16'd20000 : exp_pwm + 16'd100;
            n_cmp++; if (pwm_thres !== exp_pwm) begin n_err++; $display("FAIL clamp_step%0d: pwm got %0d want %0d", n_pulses, pwm_thres, exp_pwm); end
            tick();
        end
        n_cmp++; if (n_pulses !== 199) begin n_err++; $display("FAIL clamp_pulses: got %0d want 199", n_pulses); end
        pulse();
        n_cmp++; if (pwm_thres !== 16'd20000) begin n_err++; $display("FAIL clamp_final: pwm got %0d want 20000", pwm_thres); end
    endtask

    task automatic test_estop();
        logic [15:0] exp_pwm [11];
        logic        exp_dir [11];
        do_reset();
        // reversal from standstill still sequences the full dead time
        exp_pwm = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd100, 16'd200, 16'd300, 16'd400, 16'd500};
        exp_dir = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        send_cmd(1'b1, 16'd1000);
        for (int i = 0; i < 11; i++) begin
            pulse();
            n_cmp++; if (pwm_thres !== exp_pwm[i]) begin n_err++; $display("FAIL estop_pre_pwm%0d: got %0d want %0d", i, pwm_thres, exp_pwm[i]); end
            n_cmp++; if (motor_dir !== exp_dir[i]) begin n_err++; $display("FAIL estop_pre_dir%0d: got %0b want %0b", i, motor_dir, exp_dir[i]); end
            tick();
        end
        estop     = 1'b1;
        cmd_valid = 1'b1;
        cmd_dir   = 1'b0;
        cmd_mag   = 16'd900;
        #1;
        n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL estop_ready: got %0b want 0", cmd_ready); end
        n_cmp++; if (pwm_thres !== 16'd500) begin n_err++; $display("FAIL estop_before_edge: pwm got %0d want 500", pwm_thres); end
        tick();
        n_cmp++; if (pwm_thres !== 16'd0) begin n_err++; $display("FAIL estop_pwm: got %0d want 0", pwm_thres); end
        n_cmp++; if (motor_dir !== 1'b1) begin n_err++; $display("FAIL estop_dir: got %0b want 1", motor_dir); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL estop_busy: got %0b want 1", busy); end
        pulse();
        n_cmp++; if (pwm_thres !== 16'd0) begin n_err++; $display("FAIL estop_hold: pwm got %0d want 0", pwm_thres); end
        cmd_valid = 1'b0;
        estop     = 1'b0;
        tick();
        n_cmp++; if (at_target !== 1'b1) begin n_err++; $display("FAIL estop_release_idle: got %0b want 1", at_target); end
        pulse();
        n_cmp++; if (pwm_thres !== 16'd0) begin n_err++; $display("FAIL estop_target_cleared: pwm got %0d want 0", pwm_thres); end
        n_cmp++; if (motor_dir !== 1'b1) begin n_err++; $display("FAIL estop_release_dir: got %0b want 1", motor_dir); end
    endtask

    task automatic test_reset_mid_brake();
        do_reset();
        send_cmd(1'b0, 16'd300);
        idle_cycles(1);
        for (int i = 0; i < 3; i++) pulse();
        send_cmd(1'b1, 16'd300);
        pulse();
        n_cmp++; if (pwm_thres !== 16'd200) begin n_err++; $display("FAIL brake_before_rst: pwm got %0d want 200", pwm_thres); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL brake_busy: got %0b want 1", busy); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (pwm_thres !== 16'd0) begin n_err++; $display("FAIL async_rst_pwm: got %0d want 0", pwm_thres); end
        n_cmp++; if (motor_dir !== 1'b0) begin n_err++; $display("FAIL async_rst_dir: got %0b want 0", motor_dir); end
        n_cmp++; if (at_target !== 1'b1) begin n_err++; $display("FAIL async_rst_at_target: got %0b want 1", at_target); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL async_rst_busy: got %0b want 0", busy); end
        tick();
        rst_n = 1'b1;
        tick();
        send_cmd(1'b0, 16'd400);
        idle_cycles(4);
        n_cmp++; if (pwm_thres !== 16'd0) begin n_err++; $display("FAIL no_pulse_no_change: pwm got %0d want 0", pwm_thres); end
        pulse();
        n_cmp++; if (pwm_thres !== 16'd100) begin n_err++; $display("FAIL post_rst_step: pwm got %0d want 100", pwm_thres); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        // command and period_start together: this period steps toward the old target
        cmd_valid    = 1'b1;
        cmd_dir      = 1'b0;
        cmd_mag      = 16'd300;
        period_start = 1'b1;
        tick();
        cmd_valid    = 1'b0;
        period_start = 1'b0;
        n_cmp++; if (pwm_thres !== 16'd0) begin n_err++; $display("FAIL same_cycle_old_tgt: pwm got %0d want 0", pwm_thres); end
        n_cmp++; if (at_target !== 1'b1) begin n_err++; $display("FAIL same_cycle_idle: got %0b want 1", at_target); end
        // latest command wins
        send_cmd(1'b0, 16'd300);
        send_cmd(1'b0, 16'd150);
        pulse();
        n_cmp++; if (pwm_thres !== 16'd100) begin n_err++; $display("FAIL b2b_step1: pwm got %0d want 100", pwm_thres); end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy: got %0b want 1", busy); end
        tick();
        pulse();
        n_cmp++; if (pwm_thres !== 16'd150) begin n_err++; $display("FAIL b2b_step2: pwm got %0d want 150", pwm_thres); end
        n_cmp++; if (at_target !== 1'b1) begin n_err++; $display("FAIL b2b_at_target: got %0b want 1", at_target); end
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        rst_n        = 1'b0;
        cmd_valid    = 1'b0;
        cmd_dir      = 1'b0;
        cmd_mag      = 16'd0;
        period_start = 1'b0;
        estop        = 1'b0;
        test_reset();
        test_ramp_up();
        test_reversal();
        test_dead_abort();
        test_clamp();
        test_estop();
        test_reset_mid_brake();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
